// File: rtl/peripheral_mpram_ahb4_arbiter.sv
// Upstream stage of the MPRAM AHB4 slave: merges NUM_MASTERS AHB-Lite masters onto one slave port
// through per-master address-phase holding registers, round-robin arbitration and HMASTLOCK support.
module peripheral_mpram_ahb4_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int PLEN        = 8,
  parameter int XLEN        = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [NUM_MASTERS-1:0]      mst_HSEL,
  input  logic [NUM_MASTERS*PLEN-1:0] mst_HADDR,
  input  logic [NUM_MASTERS*XLEN-1:0] mst_HWDATA,
  output logic [NUM_MASTERS*XLEN-1:0] mst_HRDATA,
  input  logic [NUM_MASTERS-1:0]      mst_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]    mst_HSIZE,
  input  logic [NUM_MASTERS*3-1:0]    mst_HBURST,
  input  logic [NUM_MASTERS*4-1:0]    mst_HPROT,
  input  logic [NUM_MASTERS*2-1:0]    mst_HTRANS,
  input  logic [NUM_MASTERS-1:0]      mst_HMASTLOCK,
  input  logic [NUM_MASTERS-1:0]      mst_HREADY,
  output logic [NUM_MASTERS-1:0]      mst_HREADYOUT,
  output logic [NUM_MASTERS-1:0]      mst_HRESP,
  output logic                        slv_HSEL,
  output logic [PLEN-1:0]             slv_HADDR,
  output logic [XLEN-1:0]             slv_HWDATA,
  input  logic [XLEN-1:0]             slv_HRDATA,
  output logic                        slv_HWRITE,
  output logic [2:0]                  slv_HSIZE,
  output logic [2:0]                  slv_HBURST,
  output logic [3:0]                  slv_HPROT,
  output logic [1:0]                  slv_HTRANS,
  output logic                        slv_HMASTLOCK,
  output logic                        slv_HREADY,
  input  logic                        slv_HREADYOUT,
  input  logic                        slv_HRESP
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef struct packed {
    logic [PLEN-1:0] addr;
    logic            write;
    logic [2:0]      size;
    logic [2:0]      burst;
    logic [3:0]      prot;
    logic [1:0]      trans;
    logic            lock;
  } req_t;

  req_t                   mst_req [NUM_MASTERS];
  req_t                   pend_q  [NUM_MASTERS];
  req_t                   win_req;

  logic [NUM_MASTERS-1:0] cap;
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] done;
  logic [NUM_MASTERS-1:0] own_hit;
  logic [NUM_MASTERS-1:0] pend_v_q, pend_v_d;
  logic [NUM_MASTERS-1:0] busy_q, busy_d;

  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          own_idx_q, own_idx_d;
  logic [IW-1:0]          lock_owner_q, lock_owner_d;
  logic [IW-1:0]          hold_idx_q, hold_idx_d;
  logic [IW-1:0]          win_idx;

  logic                   own_v_q, own_v_d;
  logic                   lock_v_q, lock_v_d;
  logic                   hold_v_q, hold_v_d;
  logic                   win_v;
  logic                   issue;
  int                     cand;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mst_req[i].addr  = mst_HADDR[i*PLEN +: PLEN];
      mst_req[i].write = mst_HWRITE[i];
      mst_req[i].size  = mst_HSIZE[i*3 +: 3];
      mst_req[i].burst = mst_HBURST[i*3 +: 3];
      mst_req[i].prot  = mst_HPROT[i*4 +: 4];
      mst_req[i].trans = mst_HTRANS[i*2 +: 2];
      mst_req[i].lock  = mst_HMASTLOCK[i];
      // Only NONSEQ/SEQ phases are latched; IDLE/BUSY complete here with a zero-wait OKAY.
      cap[i]     = mst_HSEL[i] & mst_HTRANS[i*2+1] & mst_HREADY[i];
      elig[i]    = pend_v_q[i] & (~lock_v_q | (lock_owner_q == IW'(i)));
      own_hit[i] = own_v_q & (own_idx_q == IW'(i));
      done[i]    = own_hit[i] & slv_HREADYOUT;
    end
  end

  // An address phase stalled by slave wait states stays pinned to its master until accepted.
  always_comb begin
    win_v   = hold_v_q;
    win_idx = hold_idx_q;
    cand    = 0;
    if (!hold_v_q) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
        if (!win_v && elig[cand]) begin
          win_v   = 1'b1;
          win_idx = IW'(cand);
        end
      end
    end
    win_req = pend_q[win_idx];
  end

  always_comb begin
    issue        = win_v & slv_HREADYOUT;
    rr_ptr_d     = rr_ptr_q;
    lock_v_d     = lock_v_q;
    lock_owner_d = lock_owner_q;
    own_v_d      = own_v_q;
    own_idx_d    = own_idx_q;
    hold_v_d     = win_v & ~slv_HREADYOUT;
    hold_idx_d   = win_idx;
    if (issue) begin
      rr_ptr_d     = (win_idx == IW'(NUM_MASTERS-1)) ? '0 : win_idx + IW'(1);
      lock_v_d     = win_req.lock;
      lock_owner_d = win_idx;
    end
    if (slv_HREADYOUT) begin
      own_v_d   = issue;
      own_idx_d = win_idx;
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      pend_v_d[i] = cap[i] | (pend_v_q[i] & ~(issue & (win_idx == IW'(i))));
      busy_d[i]   = cap[i] | (busy_q[i] & ~done[i]);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_v_q     <= '0;
      busy_q       <= '0;
      rr_ptr_q     <= '0;
      own_v_q      <= 1'b0;
      own_idx_q    <= '0;
      lock_v_q     <= 1'b0;
      lock_owner_q <= '0;
      hold_v_q     <= 1'b0;
      hold_idx_q   <= '0;
    end else begin
      pend_v_q     <= pend_v_d;
      busy_q       <= busy_d;
      rr_ptr_q     <= rr_ptr_d;
      own_v_q      <= own_v_d;
      own_idx_q    <= own_idx_d;
      lock_v_q     <= lock_v_d;
      lock_owner_q <= lock_owner_d;
      hold_v_q     <= hold_v_d;
      hold_idx_q   <= hold_idx_d;
    end
  end

  // Holding-register payload is qualified by pend_v_q, so it needs no reset.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (cap[i]) pend_q[i] <= mst_req[i];
    end
  end

  always_comb begin
    slv_HSEL      = win_v;
    slv_HADDR     = win_v ? win_req.addr  : '0;
    slv_HWRITE    = win_v ? win_req.write : 1'b0;
    slv_HSIZE     = win_v ? win_req.size  : 3'b000;
    slv_HBURST    = win_v ? win_req.burst : 3'b000;
    slv_HPROT     = win_v ? win_req.prot  : 4'b0000;
    slv_HTRANS    = win_v ? win_req.trans : 2'b00;
    slv_HMASTLOCK = win_v ? win_req.lock  : lock_v_q;
    slv_HREADY    = slv_HREADYOUT;
    slv_HWDATA    = own_v_q ? mst_HWDATA[int'(own_idx_q)*XLEN +: XLEN] : '0;
    mst_HRDATA    = '0;
    mst_HRESP     = '0;
    mst_HREADYOUT = '1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mst_HRDATA[i*XLEN +: XLEN] = own_hit[i] ? slv_HRDATA : '0;
      mst_HRESP[i]               = own_hit[i] & slv_HRESP;
      mst_HREADYOUT[i]           = ~busy_q[i] | done[i];
    end
  end

endmodule

// File: tb/tb_peripheral_mpram_ahb4_arbiter.sv
// Directed bench for peripheral_mpram_ahb4_arbiter: two AHB-Lite masters, behavioural MPRAM slave
// with configurable wait states and an ERROR response on address 0xE0.
module tb_peripheral_mpram_ahb4_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        m_sel   [2];
  logic        m_write [2];
  logic        m_lock  [2];
  logic [1:0]  m_trans [2];
  logic [7:0]  m_addr  [2];
  logic [31:0] m_wdata [2];

  logic [1:0]  mst_HSEL, mst_HWRITE, mst_HMASTLOCK, mst_HREADY, mst_HREADYOUT, mst_HRESP;
  logic [15:0] mst_HADDR;
  logic [63:0] mst_HWDATA, mst_HRDATA;
  logic [5:0]  mst_HSIZE, mst_HBURST;
  logic [7:0]  mst_HPROT;
  logic [3:0]  mst_HTRANS;

  logic        slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADY, slv_HREADYOUT, slv_HRESP;
  logic [7:0]  slv_HADDR;
  logic [31:0] slv_HWDATA, slv_HRDATA;
  logic [2:0]  slv_HSIZE, slv_HBURST;
  logic [3:0]  slv_HPROT;
  logic [1:0]  slv_HTRANS;

  assign mst_HSEL      = {m_sel[1], m_sel[0]};
  assign mst_HWRITE    = {m_write[1], m_write[0]};
  assign mst_HMASTLOCK = {m_lock[1], m_lock[0]};
  assign mst_HTRANS    = {m_trans[1], m_trans[0]};
  assign mst_HADDR     = {m_addr[1], m_addr[0]};
  assign mst_HWDATA    = {m_wdata[1], m_wdata[0]};
  assign mst_HSIZE     = 6'b010_010;
  assign mst_HBURST    = 6'b000_000;
  assign mst_HPROT     = 8'b0011_0011;
  assign mst_HREADY    = mst_HREADYOUT;

  peripheral_mpram_ahb4_arbiter #(.NUM_MASTERS(2), .PLEN(8), .XLEN(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .mst_HSEL(mst_HSEL), .mst_HADDR(mst_HADDR), .mst_HWDATA(mst_HWDATA), .mst_HRDATA(mst_HRDATA),
    .mst_HWRITE(mst_HWRITE), .mst_HSIZE(mst_HSIZE), .mst_HBURST(mst_HBURST), .mst_HPROT(mst_HPROT),
    .mst_HTRANS(mst_HTRANS), .mst_HMASTLOCK(mst_HMASTLOCK), .mst_HREADY(mst_HREADY),
    .mst_HREADYOUT(mst_HREADYOUT), .mst_HRESP(mst_HRESP),
    .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA), .slv_HRDATA(slv_HRDATA),
    .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST), .slv_HPROT(slv_HPROT),
    .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK), .slv_HREADY(slv_HREADY),
    .slv_HREADYOUT(slv_HREADYOUT), .slv_HRESP(slv_HRESP)
  );

  // Behavioural slave
  logic [31:0] mem [256];
  int          ws_cfg = 0;
  logic        dp_v, dp_wr;
  logic [7:0]  dp_addr;
  int          dp_wait, dp_err;
  int          cyc;
  int          idle_lock_cnt;
  logic [7:0]  log_addr [$];
  int          log_cyc  [$];

  always_comb begin
    slv_HREADYOUT = 1'b1;
    slv_HRESP     = 1'b0;
    slv_HRDATA    = '0;
    if (dp_v) begin
      if (dp_wait > 0) slv_HREADYOUT = 1'b0;
      else if (dp_err == 1) begin slv_HREADYOUT = 1'b0; slv_HRESP = 1'b1; end
      else if (dp_err == 2) slv_HRESP = 1'b1;
      else if (!dp_wr) slv_HRDATA = mem[dp_addr];
    end
  end

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_v <= 1'b0; dp_wr <= 1'b0; dp_addr <= '0; dp_wait <= 0; dp_err <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
    end else begin
      if (slv_HREADYOUT) begin
        if (dp_v && dp_wr && dp_err == 0) mem[dp_addr] <= slv_HWDATA;
        if (slv_HSEL && slv_HTRANS[1]) begin
          dp_v <= 1'b1; dp_wr <= slv_HWRITE; dp_addr <= slv_HADDR; dp_wait <= ws_cfg;
          dp_err <= (slv_HADDR == 8'hE0) ? 1 : 0;
          log_addr.push_back(slv_HADDR);
          log_cyc.push_back(cyc);
        end else dp_v <= 1'b0;
      end else begin
        if (dp_wait > 0) dp_wait <= dp_wait - 1;
        else if (dp_err == 1) dp_err <= 2;
      end
      if (!slv_HSEL && slv_HMASTLOCK) idle_lock_cnt <= idle_lock_cnt + 1;
    end
  end

  int          stable_viol = 0;
  int          hresp_leak  = 0;
  logic        prev_pend   = 1'b0;
  logic [7:0]  prev_addr   = '0;
  always @(negedge HCLK) begin
    if (!HRESETn) prev_pend <= 1'b0;
    else begin
      if (prev_pend && (!slv_HSEL || slv_HADDR != prev_addr)) stable_viol <= stable_viol + 1;
      prev_pend <= slv_HSEL && slv_HTRANS[1] && !slv_HREADYOUT;
      prev_addr <= slv_HADDR;
    end
    if (mst_HRESP[1]) hresp_leak <= hresp_leak + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic [31:0] res_rdata [2];
  logic        res_resp  [2];
  logic        res_err1  [2];
  int          res_waits [2];

  // One transfer from master m; called just after a rising edge, returns just after one.
  task automatic xfer(input int m, input bit wr, input logic [7:0] a, input logic [31:0] wd, input bit lk);
    bit ok;
    int n;
    m_sel[m] = 1'b1; m_trans[m] = 2'b10; m_addr[m] = a; m_write[m] = wr; m_lock[m] = lk;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge HCLK); ok = mst_HREADYOUT[m];
      @(posedge HCLK); n++;
    end
    #1;
    m_sel[m] = 1'b0; m_trans[m] = 2'b00; m_lock[m] = 1'b0; m_wdata[m] = wd;
    if (!ok) check("addr_timeout", 32'd0, 32'd1);
    res_waits[m] = 0; res_err1[m] = 1'b0; res_resp[m] = 1'b0; res_rdata[m] = '0;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge HCLK);
      if (mst_HRESP[m] && !mst_HREADYOUT[m]) res_err1[m] = 1'b1;
      if (mst_HREADYOUT[m]) begin
        ok = 1'b1; res_rdata[m] = mst_HRDATA[m*32 +: 32]; res_resp[m] = mst_HRESP[m];
      end else res_waits[m]++;
      n++;
    end
    if (!ok) check("data_timeout", 32'd0, 32'd1);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int          base, ilc;
  logic [31:0] v;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 1'b0; m_write[i] = 1'b0; m_lock[i] = 1'b0;
      m_trans[i] = 2'b00; m_addr[i] = '0; m_wdata[i] = '0;
    end
    cyc = 0; idle_lock_cnt = 0;
    repeat (3) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    check("rst_hreadyout", 32'(mst_HREADYOUT), 32'h3);
    check("rst_hresp",     32'(mst_HRESP), 32'h0);
    check("rst_hrdata",    mst_HRDATA[31:0] | mst_HRDATA[63:32], 32'h0);
    check("rst_slv_hsel",  32'(slv_HSEL), 32'h0);
    check("rst_slv_htrans", 32'(slv_HTRANS), 32'h0);
    check("rst_slv_lock",  32'(slv_HMASTLOCK), 32'h0);

    // Single master write then read back
    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    check("t1_wr_waits", 32'(res_waits[0]), 32'd1);
    check("t1_mem", mem[8'h10], 32'hDEADBEEF);
    xfer(0, 1'b0, 8'h10, 32'h0, 1'b0);
    check("t1_rd_data", res_rdata[0], 32'hDEADBEEF);
    check("t1_rd_waits", 32'(res_waits[0]), 32'd1);
    check("t1_rd_resp", 32'(res_resp[0]), 32'd0);

    // M1 alone brings rr back to 0
    xfer(1, 1'b1, 8'h20, 32'h11112222, 1'b0);
    check("t2_pre_waits", 32'(res_waits[1]), 32'd1);

    // Simultaneous requests, rr = 0
    base = log_addr.size();
    fork
      xfer(0, 1'b0, 8'h10, 32'h0, 1'b0);
      xfer(1, 1'b1, 8'h24, 32'h33334444, 1'b0);
    join
    check("t2_order0", 32'(log_addr[base]), 32'h10);
    check("t2_order1", 32'(log_addr[base+1]), 32'h24);
    check("t2_gap", 32'(log_cyc[base+1] - log_cyc[base]), 32'd1);
    check("t2_m0_waits", 32'(res_waits[0]), 32'd1);
    check("t2_m1_waits", 32'(res_waits[1]), 32'd2);
    check("t2_m0_data", res_rdata[0], 32'hDEADBEEF);
    check("t2_mem", mem[8'h24], 32'h33334444);

    // rr back at 0: M0 wins again
    base = log_addr.size();
    fork
      xfer(0, 1'b1, 8'h28, 32'h55556666, 1'b0);
      xfer(1, 1'b0, 8'h24, 32'h0, 1'b0);
    join
    check("t2b_order0", 32'(log_addr[base]), 32'h28);
    check("t2b_m1_data", res_rdata[1], 32'h33334444);

    // Two slave wait states
    ws_cfg = 2;
    base = stable_viol;
    fork
      xfer(0, 1'b0, 8'h20, 32'h0, 1'b0);
      xfer(1, 1'b0, 8'h28, 32'h0, 1'b0);
    join
    ws_cfg = 0;
    check("t3_m0_waits", 32'(res_waits[0]), 32'd3);
    check("t3_m1_waits", 32'(res_waits[1]), 32'd6);
    check("t3_m0_data", res_rdata[0], 32'h11112222);
    check("t3_m1_data", res_rdata[1], 32'h55556666);
    check("t3_addr_stable", 32'(stable_viol - base), 32'd0);

    // M1 locked read-modify-write, M0 contending
    base = log_addr.size();
    ilc = idle_lock_cnt;
    fork
      begin
        xfer(1, 1'b0, 8'h30, 32'h0, 1'b1);
        v = res_rdata[1] + 32'd1;
        xfer(1, 1'b1, 8'h30, v, 1'b1);
        xfer(1, 1'b0, 8'h40, 32'h0, 1'b0);
      end
      begin
        @(posedge HCLK); #1;
        xfer(0, 1'b1, 8'h50, 32'hCAFEF00D, 1'b0);
      end
    join
    check("t4_order0", 32'(log_addr[base]), 32'h30);
    check("t4_order1", 32'(log_addr[base+1]), 32'h30);
    check("t4_order2", 32'(log_addr[base+2]), 32'h40);
    check("t4_order3", 32'(log_addr[base+3]), 32'h50);
    check("t4_idle_lock", 32'(idle_lock_cnt - ilc), 32'd4);
    check("t4_m0_waits", 32'(res_waits[0]), 32'd7);
    check("t4_rmw_mem", mem[8'h30], 32'hA500_0031);
    check("t4_m0_mem", mem[8'h50], 32'hCAFEF00D);
    check("t4_unlocked", 32'(slv_HMASTLOCK), 32'd0);

    // Slave ERROR on M0 read, M1 served first (rr = 1)
    fork
      xfer(0, 1'b0, 8'hE0, 32'h0, 1'b0);
      xfer(1, 1'b0, 8'h20, 32'h0, 1'b0);
    join
    check("t5_m0_err_first", 32'(res_err1[0]), 32'd1);
    check("t5_m0_resp", 32'(res_resp[0]), 32'd1);
    check("t5_m0_waits", 32'(res_waits[0]), 32'd3);
    check("t5_m1_resp", 32'(res_resp[1]), 32'd0);
    check("t5_m1_data", res_rdata[1], 32'h11112222);
    check("t5_m1_waits", 32'(res_waits[1]), 32'd1);
    check("t5_m1_no_leak", 32'(hresp_leak), 32'd0);

    // Async reset with both masters pending
    ws_cfg = 3;
    m_sel[0] = 1'b1; m_trans[0] = 2'b10; m_addr[0] = 8'h60; m_write[0] = 1'b0;
    m_sel[1] = 1'b1; m_trans[1] = 2'b10; m_addr[1] = 8'h70; m_write[1] = 1'b0;
    @(posedge HCLK); #1;
    for (int i = 0; i < 2; i++) begin m_sel[i] = 1'b0; m_trans[i] = 2'b00; end
    @(posedge HCLK); #1;
    check("t6_pre_hsel", 32'(slv_HSEL), 32'd1);
    check("t6_pre_haddr", 32'(slv_HADDR), 32'h60);
    check("t6_pre_ready", 32'(mst_HREADYOUT), 32'h0);
    #2 HRESETn = 1'b0;
    #1;
    check("t6_rst_hreadyout", 32'(mst_HREADYOUT), 32'h3);
    check("t6_rst_hsel", 32'(slv_HSEL), 32'd0);
    check("t6_rst_htrans", 32'(slv_HTRANS), 32'd0);
    check("t6_rst_lock", 32'(slv_HMASTLOCK), 32'd0);
    check("t6_rst_hresp", 32'(mst_HRESP), 32'd0);
    ws_cfg = 0;
    @(posedge HCLK); #3 HRESETn = 1'b1;
    base = log_addr.size();
    repeat (6) @(posedge HCLK);
    #1;
    check("t6_no_stale_issue", 32'(log_addr.size() - base), 32'd0);
    check("t6_post_hsel", 32'(slv_HSEL), 32'd0);
    check("t6_post_hreadyout", 32'(mst_HREADYOUT), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
